paint_cmd_executor: RTL and testbench
=====================================

// Module: paint_cmd_executor
// PURPOSE
//  Consumes decoded paint commands (cmd/x/y + one-cycle valid pulse) from the UART
//  packet decoder in top_fpga and turns them into framebuffer write transactions.
//  Buffers commands in a small FIFO so multi-cycle operations (screen clear) never lose input.
//  Tracks cursor position and current colour; feeds the 64x64 framebuffer write port.
// PARAMETERS
//  COORD_W     6   bits per coordinate; framebuffer is 2^COORD_W x 2^COORD_W
//  COLOR_W     3   bits per pixel colour
//  FIFO_DEPTH  4   command FIFO entries (power of two, >=2)
// PORTS
//  clk          in   1            system clock (50 MHz)
//  reset        in   1            asynchronous, active-high reset
//  cmd_in       in   3            command code from packet decoder
//  x_in         in   COORD_W      X operand
//  y_in         in   COORD_W      Y operand
//  cmd_valid    in   1            one-cycle strobe: cmd/x/y valid this cycle
//  fb_we        out  1            framebuffer write enable (registered)
//  fb_addr      out  2*COORD_W    write address = {y, x}
//  fb_wdata     out  COLOR_W      write pixel value
//  cursor_x     out  COORD_W      current cursor X
//  cursor_y     out  COORD_W      current cursor Y
//  busy         out  1            high while in CLEAR state or FIFO non-empty
//  overflow     out  1            sticky: a command was dropped on a full FIFO
// BEHAVIOUR
//  Reset (async, active-high): all outputs 0, colour reg = all-ones, FIFO empty, FSM=IDLE.
//  Reset asserted mid-CLEAR abandons the sweep immediately; no further writes.
//  Command codes: 0 NOP; 1 MOVE; 2 DRAW; 3 ERASE; 4 SET_COLOR; 5 CLEAR; 6,7 reserved (popped, ignored).
//  FIFO push on clk edge where cmd_valid=1 and (count<FIFO_DEPTH or pop same edge).
//  Push refused when full and no pop -> command dropped, overflow<=1 (cleared only by reset).
//  Pop: in IDLE with FIFO non-empty, one entry per edge. Latency: cmd_valid at edge E0,
//   its effect (fb_we/cursor update) registered at E1, visible after E1.
//  MOVE: cursor<=(x,y); fb_we=0.
//  DRAW: cursor<=(x,y); fb_we=1, fb_addr={y,x}, fb_wdata=colour.
//  ERASE: as DRAW but fb_wdata=0.
//  SET_COLOR: colour<=x_in[COLOR_W-1:0]; cursor unchanged; fb_we=0.
//  CLEAR: FSM->CLEAR, counter<=0. Each CLEAR cycle: fb_we=1, fb_addr=counter, fb_wdata=0,
//   counter+1. After writing address 2^(2*COORD_W)-1 -> IDLE (4096 write cycles default).
//   Cursor and colour unchanged by CLEAR. FIFO keeps accepting pushes during CLEAR (no pops).
//  fb_we is a single-cycle pulse per DRAW/ERASE; deasserted in any cycle with no write.
//  States: IDLE (pop+execute 1-cycle cmds) -> CLEAR (on CLEAR pop) -> IDLE (counter wrap).
//  Coordinates are used unmodified (no clipping needed: width = COORD_W).
//  busy = (state==CLEAR) | ~fifo_empty.
// STRUCTURE
//  retro_paint_pkg: COORD_W/COLOR_W defaults, cmd_e enum (CMD_NOP..CMD_CLEAR),
//   paint_cmd_t struct {cmd_e cmd; x; y}.
//  Sub-module paint_cmd_fifo: sync FIFO of paint_cmd_t, ports push/pop/full/empty/count.
//  Executor FSM, cursor/colour regs and clear counter in this module.
// TESTING
//  Reset then MOVE(10,5) -> fb_we stays 0; cursor=(10,5) one edge after pop.
//  SET_COLOR(x=3), DRAW(10,5) -> one fb_we pulse, fb_addr=0x14A, fb_wdata=3.
//  ERASE(63,63) -> fb_we pulse, fb_addr=0xFFF, fb_wdata=0; cursor=(63,63).
//  CLEAR then DRAW(1,1) back-to-back -> 4096 writes addr 0..0xFFF data 0, then DRAW addr 0x041.
//  6 strobes during CLEAR -> 4 executed after sweep, overflow=1; busy high throughout.
//  Assert reset at CLEAR addr 100 -> fb_we=0 immediately, FIFO empty, cursor=(0,0), overflow=0.

Source files
------------

// File: rtl/retro_paint_pkg.sv
// Shared types for the paint command path: command codes and the decoded command record.
package retro_paint_pkg;

  localparam int unsigned CoordW    = 6;
  localparam int unsigned ColorW    = 3;
  localparam int unsigned FifoDepth = 4;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_MOVE      = 3'd1,
    CMD_DRAW      = 3'd2,
    CMD_ERASE     = 3'd3,
    CMD_SET_COLOR = 3'd4,
    CMD_CLEAR     = 3'd5
  } cmd_e;

  typedef struct packed {
    cmd_e              cmd;
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
  } paint_cmd_t;

endpackage

// File: rtl/paint_cmd_fifo.sv
// Small synchronous FIFO of paint commands; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module paint_cmd_fifo
  import retro_paint_pkg::*;
#(
  parameter int unsigned DEPTH = FifoDepth,
  parameter type         entry_t = paint_cmd_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   wdata,
  input  logic                     pop,
  output entry_t                   rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  entry_t            mem [DEPTH];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == (PtrW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (PtrW + 1)'(1);
        2'b01:   count <= count - (PtrW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/paint_cmd_executor.sv
// Executes buffered paint commands: cursor/colour tracking, single-pixel writes and a
// full-screen clear sweep onto the framebuffer write port.
module paint_cmd_executor
  import retro_paint_pkg::*;
#(
  parameter int unsigned COORD_W    = CoordW,
  parameter int unsigned COLOR_W    = ColorW,
  parameter int unsigned FIFO_DEPTH = FifoDepth
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           cmd_in,
  input  logic [COORD_W-1:0]   x_in,
  input  logic [COORD_W-1:0]   y_in,
  input  logic                 cmd_valid,
  output logic                 fb_we,
  output logic [2*COORD_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_wdata,
  output logic [COORD_W-1:0]   cursor_x,
  output logic [COORD_W-1:0]   cursor_y,
  output logic                 busy,
  output logic                 overflow
);

  localparam int unsigned AddrW = 2 * COORD_W;

  typedef struct packed {
    cmd_e               cmd;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } entry_t;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                          state;
  logic [COLOR_W-1:0]              colour;
  logic [AddrW-1:0]                clear_addr;
  entry_t                          push_entry;
  entry_t                          head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]     fifo_count;
  logic                            pop;
  logic                            push;

  assign pop        = (state == StIdle) && !fifo_empty;
  assign push       = cmd_valid && (!fifo_full || pop);
  assign push_entry = '{cmd: cmd_e'(cmd_in), x: x_in, y: y_in};
  assign busy       = (state == StClear) || (fifo_count != '0);

  paint_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      colour     <= '1;
      clear_addr <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      cursor_x   <= '0;
      cursor_y   <= '0;
      overflow   <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      if (cmd_valid && !push) overflow <= 1'b1;

      unique case (state)
        StIdle: begin
          if (pop) begin
            case (head.cmd)
              CMD_MOVE: begin
                cursor_x <= head.x;
                cursor_y <= head.y;
              end
              CMD_DRAW, CMD_ERASE: begin
                cursor_x <= head.x;
                cursor_y <= head.y;
                fb_we    <= 1'b1;
                fb_addr  <= {head.y, head.x};
                fb_wdata <= (head.cmd == CMD_DRAW) ? colour : '0;
              end
              CMD_SET_COLOR: colour <= head.x[COLOR_W-1:0];
              CMD_CLEAR: begin
                state      <= StClear;
                clear_addr <= '0;
              end
              default: ;  // NOP and reserved codes are consumed with no effect
            endcase
          end
        end
        StClear: begin
          fb_we      <= 1'b1;
          fb_addr    <= clear_addr;
          fb_wdata   <= '0;
          clear_addr <= clear_addr + AddrW'(1);
          if (clear_addr == '1) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_cmd_executor.sv
// Directed bench for paint_cmd_executor: single-cycle commands, clear sweep, overflow, reset.
module tb_paint_cmd_executor;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cmd_in;
  logic [5:0]  x_in;
  logic [5:0]  y_in;
  logic        cmd_valid;
  logic        fb_we;
  logic [11:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic [5:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic        busy;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  int bad;
  int nd;
  int draws_after_fff;
  bit seen_fff;
  bit found;
  logic [11:0] draw_addr [4];

  paint_cmd_executor dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_in    (cmd_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .cmd_valid (cmd_valid),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the falling edge right after the push edge.
  task automatic send(input logic [2:0] c, input logic [5:0] x, input logic [5:0] y);
    @(negedge clk);
    cmd_in    = c;
    x_in      = x;
    y_in      = y;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_in    = 3'd0;
    x_in      = 6'd0;
    y_in      = 6'd0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_cursor", 32'({cursor_y, cursor_x}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    // MOVE(10,5)
    send(3'd1, 6'd10, 6'd5);
    check("move_latency_cursor", 32'(cursor_x), 32'd0);
    check("move_busy_queued", 32'(busy), 32'd1);
    @(negedge clk);
    check("move_we", 32'(fb_we), 32'd0);
    check("move_cx", 32'(cursor_x), 32'd10);
    check("move_cy", 32'(cursor_y), 32'd5);
    check("move_busy_done", 32'(busy), 32'd0);

    // SET_COLOR(3) then DRAW(10,5)
    send(3'd4, 6'd3, 6'd0);
    @(negedge clk);
    check("setc_we", 32'(fb_we), 32'd0);
    check("setc_cursor", 32'({cursor_y, cursor_x}), 32'h14A);
    send(3'd2, 6'd10, 6'd5);
    @(negedge clk);
    check("draw_we", 32'(fb_we), 32'd1);
    check("draw_addr", 32'(fb_addr), 32'h14A);
    check("draw_data", 32'(fb_wdata), 32'd3);
    @(negedge clk);
    check("draw_pulse_end", 32'(fb_we), 32'd0);

    // ERASE(63,63)
    send(3'd3, 6'd63, 6'd63);
    @(negedge clk);
    check("erase_we", 32'(fb_we), 32'd1);
    check("erase_addr", 32'(fb_addr), 32'hFFF);
    check("erase_data", 32'(fb_wdata), 32'd0);
    check("erase_cursor", 32'({cursor_y, cursor_x}), 32'hFFF);

    // Reserved code 6 is consumed with no effect
    send(3'd6, 6'd1, 6'd2);
    @(negedge clk);
    check("rsv_we", 32'(fb_we), 32'd0);
    check("rsv_cursor", 32'({cursor_y, cursor_x}), 32'hFFF);
    check("rsv_busy", 32'(busy), 32'd0);

    // CLEAR followed by DRAW(1,1)
    send(3'd5, 6'd0, 6'd0);
    send(3'd2, 6'd1, 6'd1);
    for (int k = 0; k < 10 && fb_we !== 1'b1; k++) @(negedge clk);
    check("clear_start", 32'(fb_we), 32'd1);
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (!(fb_we === 1'b1 && fb_addr === 12'(i) && fb_wdata === 3'd0 && busy === 1'b1)) bad++;
      @(negedge clk);
    end
    check("clear_sweep_bad_cycles", 32'(bad), 32'd0);
    check("post_clear_draw_we", 32'(fb_we), 32'd1);
    check("post_clear_draw_addr", 32'(fb_addr), 32'h041);
    check("post_clear_draw_data", 32'(fb_wdata), 32'd3);
    check("post_clear_cursor", 32'({cursor_y, cursor_x}), 32'h041);
    @(negedge clk);
    check("post_clear_idle", 32'({busy, fb_we}), 32'd0);

    // CLEAR then six DRAW strobes: four fit, two are dropped
    send(3'd5, 6'd0, 6'd0);
    for (int i = 0; i < 6; i++) send(3'd2, 6'(i), 6'd10);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    nd = 0;
    draws_after_fff = 0;
    seen_fff = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (fb_we === 1'b1) begin
        if (fb_wdata === 3'd3) begin
          if (nd < 4) draw_addr[nd] = fb_addr;
          nd++;
          if (seen_fff) draws_after_fff++;
        end else if (fb_addr === 12'hFFF) begin
          seen_fff = 1'b1;
        end
      end
      if (busy === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("ovf_drain_done", 32'(found), 32'd1);
    check("ovf_draw_count", 32'(nd), 32'd4);
    check("ovf_draws_after_sweep", 32'(draws_after_fff), 32'd4);
    for (int i = 0; i < 4; i++) check("ovf_draw_addr", 32'(draw_addr[i]), 32'(640 + i));
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_cursor", 32'({cursor_y, cursor_x}), 32'(640 + 3));

    // Reset in the middle of a clear sweep, with a MOVE still queued
    send(3'd5, 6'd0, 6'd0);
    send(3'd1, 6'd7, 6'd7);
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (fb_we === 1'b1 && fb_addr === 12'd100) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid_reached_100", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_we", 32'(fb_we), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cursor", 32'({cursor_y, cursor_x}), 32'd0);
    check("rstmid_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (fb_we !== 1'b0) bad++;
    end
    check("rstmid_no_writes", 32'(bad), 32'd0);
    check("rstmid_move_dropped", 32'({cursor_y, cursor_x}), 32'd0);
    send(3'd2, 6'd2, 6'd2);
    @(negedge clk);
    check("rstmid_draw_addr", 32'(fb_addr), 32'h082);
    check("rstmid_colour_ones", 32'(fb_wdata), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
